// File: rtl/alu_issue_controller_if.sv
// Bundle of the handshake, register-file and ALU signals around the
// ALU issue controller. The controller uses the slave view; the
// fetch stage, register file and ALU together form the master view.
interface alu_issue_controller_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_WIDTH   = 6,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      instrValid;
  logic                      instrReady;
  logic [31:0]               instrWord;

  logic [REG_ADDR_WIDTH-1:0] regReadAddr1;
  logic [REG_ADDR_WIDTH-1:0] regReadAddr2;
  logic [DATA_WIDTH-1:0]     regReadData1;
  logic [DATA_WIDTH-1:0]     regReadData2;

  logic [OPCODE_WIDTH-1:0]   aluOpCode;
  logic [DATA_WIDTH-1:0]     aluInputData1;
  logic [DATA_WIDTH-1:0]     aluInputData2;
  logic [DATA_WIDTH-1:0]     aluOutputData;

  logic                      regWriteEnable;
  logic [REG_ADDR_WIDTH-1:0] regWriteAddr;
  logic [DATA_WIDTH-1:0]     regWriteData;

  logic                      done;
  logic                      illegalOp;
  logic                      divZeroError;

  modport slave (
    input  instrValid, instrWord, regReadData1, regReadData2, aluOutputData,
    output instrReady, regReadAddr1, regReadAddr2, aluOpCode, aluInputData1,
           aluInputData2, regWriteEnable, regWriteAddr, regWriteData, done,
           illegalOp, divZeroError
  );

  modport master (
    output instrValid, instrWord, regReadData1, regReadData2, aluOutputData,
    input  instrReady, regReadAddr1, regReadAddr2, aluOpCode, aluInputData1,
           aluInputData2, regWriteEnable, regWriteAddr, regWriteData, done,
           illegalOp, divZeroError
  );
endinterface

// File: rtl/alu_issue_controller.sv
// Sequential ALU issue controller: accepts one instruction word, reads its
// operands from the register file, drives the ALU for one cycle and writes
// the result back. One instruction every four cycles (IDLE/READ/EXEC/WB).
// Optional feature: define ALU_DIVZERO_TRAP_EN to trap DIV/MOD by zero
// (sticky divZeroError, writeback suppressed).
module alu_issue_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_WIDTH   = 6,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic                  clock,
  input logic                  reset,
  alu_issue_controller_if.slave bus
);
  localparam int IMM_WIDTH = 15;
  localparam logic [OPCODE_WIDTH-1:0] LAST_LEGAL_OP = OPCODE_WIDTH'(13);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} stateT;

  stateT state;
  stateT nextState;

  // Fields of the incoming instruction word.
  logic [OPCODE_WIDTH-1:0]   wordOpCode;
  logic [REG_ADDR_WIDTH-1:0] wordRd;
  logic [REG_ADDR_WIDTH-1:0] wordRs1;
  logic [REG_ADDR_WIDTH-1:0] wordRs2;
  logic                      wordImmSel;
  logic [IMM_WIDTH-1:0]      wordImm;

  assign wordOpCode = OPCODE_WIDTH'(bus.instrWord[31:26]);
  assign wordRd     = REG_ADDR_WIDTH'(bus.instrWord[25:21]);
  assign wordRs1    = REG_ADDR_WIDTH'(bus.instrWord[20:16]);
  assign wordImmSel = bus.instrWord[15];
  assign wordRs2    = REG_ADDR_WIDTH'(bus.instrWord[14:10]);
  assign wordImm    = bus.instrWord[14:0];

  // Captured instruction and datapath registers.
  logic [OPCODE_WIDTH-1:0]   opCodeReg;
  logic [REG_ADDR_WIDTH-1:0] rdReg;
  logic                      immSelReg;
  logic [IMM_WIDTH-1:0]      immReg;
  logic [REG_ADDR_WIDTH-1:0] readAddr1Reg;
  logic [REG_ADDR_WIDTH-1:0] readAddr2Reg;
  logic [DATA_WIDTH-1:0]     operand1Reg;
  logic [DATA_WIDTH-1:0]     operand2Reg;
  logic [DATA_WIDTH-1:0]     resultReg;
  logic                      suppressReg;
  logic                      illegalOpReg;

  logic [DATA_WIDTH-1:0]     operand2Next;
  logic                      illegalNow;
  logic                      instrReadyInt;
  logic                      doneInt;
  logic                      writeEnableInt;

  assign operand2Next = immSelReg
                      ? {{(DATA_WIDTH-IMM_WIDTH){immReg[IMM_WIDTH-1]}}, immReg}
                      : bus.regReadData2;
  assign illegalNow   = opCodeReg > LAST_LEGAL_OP;

`ifdef ALU_DIVZERO_TRAP_EN
  localparam logic [OPCODE_WIDTH-1:0] OP_DIV = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOD = OPCODE_WIDTH'(4);

  logic trapNow;
  logic divZeroReg;

  assign trapNow          = ((opCodeReg == OP_DIV) || (opCodeReg == OP_MOD))
                          && (operand2Reg == '0);
  assign bus.divZeroError = divZeroReg;
`else
  assign bus.divZeroError = 1'b0;
`endif

  // State register; reset returns to IDLE and aborts any instruction in flight.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic and the per-state handshake/strobe outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    nextState      = state;
    instrReadyInt  = 1'b0;
    doneInt        = 1'b0;
    writeEnableInt = 1'b0;
    case (state)
      IDLE: begin
        instrReadyInt = !reset;
        if (bus.instrValid && !reset) nextState = READ;
      end
      READ: nextState = EXEC;
      EXEC: nextState = WB;
      WB: begin
        doneInt        = !reset;
        writeEnableInt = !reset && !suppressReg && (rdReg != '0);
        nextState      = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Datapath: capture the instruction, latch operands, capture the ALU result.
  always_ff @(posedge clock) begin
    if (reset) begin
      opCodeReg    <= '0;
      rdReg        <= '0;
      immSelReg    <= 1'b0;
      immReg       <= '0;
      readAddr1Reg <= '0;
      readAddr2Reg <= '0;
      operand1Reg  <= '0;
      operand2Reg  <= '0;
      resultReg    <= '0;
      suppressReg  <= 1'b0;
      illegalOpReg <= 1'b0;
`ifdef ALU_DIVZERO_TRAP_EN
      divZeroReg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.instrValid) begin
            opCodeReg    <= wordOpCode;
            rdReg        <= wordRd;
            immSelReg    <= wordImmSel;
            immReg       <= wordImm;
            readAddr1Reg <= wordRs1;
            readAddr2Reg <= wordRs2;
          end
        end
        READ: begin
          operand1Reg <= bus.regReadData1;
          operand2Reg <= operand2Next;
        end
        EXEC: begin
          resultReg <= bus.aluOutputData;
          if (illegalNow) illegalOpReg <= 1'b1;
`ifdef ALU_DIVZERO_TRAP_EN
          suppressReg <= illegalNow || trapNow;
          if (trapNow) divZeroReg <= 1'b1;
`else
          suppressReg <= illegalNow;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.instrReady     = instrReadyInt;
  assign bus.regReadAddr1   = readAddr1Reg;
  assign bus.regReadAddr2   = readAddr2Reg;
  assign bus.aluOpCode      = opCodeReg;
  assign bus.aluInputData1  = operand1Reg;
  assign bus.aluInputData2  = operand2Reg;
  assign bus.regWriteEnable = writeEnableInt;
  assign bus.regWriteAddr   = rdReg;
  assign bus.regWriteData   = resultReg;
  assign bus.done           = doneInt;
  assign bus.illegalOp      = illegalOpReg;
endmodule

// File: tb/tb_alu_issue_controller.sv
// Testbench for alu_issue_controller: bench-side register file and ALU,
// a transaction-level reference model, a per-cycle compare process,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_issue_controller;
  localparam int DW = 32;
  localparam int OW = 6;
  localparam int AW = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_issue_controller_if #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .REG_ADDR_WIDTH(AW)) bus ();

  alu_issue_controller #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .REG_ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Reference ALU behaviour (division by zero given defined results).
  function automatic logic [31:0] aluRef(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      6'd0:  return a + b;
      6'd1:  return a - b;
      6'd2:  return a * b;
      6'd3:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      6'd4:  return (b == 0) ? a : a % b;
      6'd5:  return a << b[4:0];
      6'd6:  return a >> b[4:0];
      6'd7:  return a & b;
      6'd8:  return a | b;
      6'd9:  return ~a;
      6'd10: return {31'd0, a == b};
      6'd11: return {31'd0, a != b};
      6'd12: return {31'd0, $signed(a) < $signed(b)};
      6'd13: return {31'd0, $signed(a) <= $signed(b)};
      default: return a ^ b ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  // Environment: register file (combinational read, clocked write) and ALU.
  logic [31:0] envRegs [32];
  assign bus.regReadData1  = envRegs[bus.regReadAddr1];
  assign bus.regReadData2  = envRegs[bus.regReadAddr2];
  assign bus.aluOutputData = aluRef(bus.aluOpCode, bus.aluInputData1, bus.aluInputData2);

  always @(posedge clock) begin
    if (bus.regWriteEnable === 1'b1) envRegs[bus.regWriteAddr] <= bus.regWriteData;
  end

  // Reference model: one instruction in flight, retiring three cycles
  // after acceptance; the architectural register file is mRegs.
  logic [31:0] mRegs [32];
  bit          started     = 0;
  bit          mPending    = 0;
  int          mAge        = 0;
  int          mAcceptCount = 0;
  logic [5:0]  mOp;
  logic [4:0]  mRd;
  logic [31:0] mA, mB, mRes;
  bit          mTrap, mWriteOk;
  bit          mIllegal = 0;
  bit          mDivZero = 0;
  logic [4:0]  mLastA1 = '0;
  logic [4:0]  mLastA2 = '0;

  always @(posedge clock) begin
    logic [31:0] w;
    started = 1;
    if (reset) begin
      mPending = 0;
      mIllegal = 0;
      mDivZero = 0;
      mLastA1  = '0;
      mLastA2  = '0;
    end else if (mPending) begin
      mAge++;
      if (mAge == 3) begin
        if (mOp > 13) mIllegal = 1;
        if (mTrap)    mDivZero = 1;
      end
      if (mAge == 4) begin
        if (mWriteOk) mRegs[mRd] = mRes;
        mPending = 0;
      end
    end else if (bus.instrValid) begin
      w       = bus.instrWord;
      mOp     = w[31:26];
      mRd     = w[25:21];
      mLastA1 = w[20:16];
      mLastA2 = w[14:10];
      mA      = mRegs[w[20:16]];
      mB      = w[15] ? {{17{w[14]}}, w[14:0]} : mRegs[w[14:10]];
      mRes    = aluRef(mOp, mA, mB);
`ifdef ALU_DIVZERO_TRAP_EN
      mTrap   = (mOp == 3 || mOp == 4) && (mB == 0);
`else
      mTrap   = 0;
`endif
      mWriteOk = (mRd != 0) && (mOp <= 13) && !mTrap;
      mPending = 1;
      mAge     = 1;
      mAcceptCount++;
    end
  end

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clock) begin
    bit eDone, eWe;
    if (started) begin
      eDone = mPending && (mAge == 3) && !reset;
      eWe   = eDone && mWriteOk;
      checkBit("instrReady", bus.instrReady, !reset && !mPending);
      check("regReadAddr1", {27'd0, bus.regReadAddr1}, {27'd0, mLastA1});
      check("regReadAddr2", {27'd0, bus.regReadAddr2}, {27'd0, mLastA2});
      checkBit("done", bus.done, eDone);
      checkBit("regWriteEnable", bus.regWriteEnable, eWe);
      if (eWe) begin
        check("regWriteAddr", {27'd0, bus.regWriteAddr}, {27'd0, mRd});
        check("regWriteData", bus.regWriteData, mRes);
      end
      if (mPending && mAge == 2 && !reset) begin
        check("aluOpCode", {26'd0, bus.aluOpCode}, {26'd0, mOp});
        check("aluInputData1", bus.aluInputData1, mA);
        check("aluInputData2", bus.aluInputData2, mB);
      end
      checkBit("illegalOp", bus.illegalOp, mIllegal);
      checkBit("divZeroError", bus.divZeroError, mDivZero);
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic setReg(input int r, input logic [31:0] v);
    envRegs[r] = v;
    mRegs[r]   = v;
  endtask

  function automatic logic [31:0] mkR(input int op, input int rd, input int rs1, input int rs2);
    return {op[5:0], rd[4:0], rs1[4:0], 1'b0, rs2[4:0], 10'd0};
  endfunction

  function automatic logic [31:0] mkI(input int op, input int rd, input int rs1, input logic [14:0] imm);
    return {op[5:0], rd[4:0], rs1[4:0], 1'b1, imm};
  endfunction

  // Present a word and wait (bounded) until it is accepted; returns in READ.
  task automatic issue(input logic [31:0] w, input bit hold);
    int c0;
    c0 = mAcceptCount;
    bus.instrWord  = w;
    bus.instrValid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mAcceptCount != c0) break;
    end
    checkBit("accept_within_budget", mAcceptCount != c0, 1'b1);
    if (!hold) bus.instrValid = 1'b0;
  endtask

  initial begin
    logic [31:0] prev9;
    int c0;
    for (int i = 0; i < 32; i++) setReg(i, (i == 0) ? 32'd0 : $urandom);
    setReg(1, 32'd5);
    setReg(2, 32'd7);
    bus.instrValid = 1'b0;
    bus.instrWord  = '0;

    // Reset state.
    repeat (3) step();
    checkBit("rst_instrReady", bus.instrReady, 1'b0);
    checkBit("rst_regWriteEnable", bus.regWriteEnable, 1'b0);
    checkBit("rst_done", bus.done, 1'b0);
    checkBit("rst_illegalOp", bus.illegalOp, 1'b0);
    checkBit("rst_divZeroError", bus.divZeroError, 1'b0);
    check("rst_aluOpCode", {26'd0, bus.aluOpCode}, 32'd0);
    check("rst_aluInputData1", bus.aluInputData1, 32'd0);
    check("rst_aluInputData2", bus.aluInputData2, 32'd0);
    check("rst_regReadAddr1", {27'd0, bus.regReadAddr1}, 32'd0);
    check("rst_regWriteData", bus.regWriteData, 32'd0);
    reset = 1'b0;
    step();
    checkBit("ready_after_reset", bus.instrReady, 1'b1);

    // ADD rd=3, rs1=1 (5), rs2=2 (7).
    issue(mkR(0, 3, 1, 2), 0);
    checkBit("add_read_ready_low", bus.instrReady, 1'b0);
    step();
    check("add_alu_in1", bus.aluInputData1, 32'd5);
    check("add_alu_in2", bus.aluInputData2, 32'd7);
    step();
    checkBit("add_we", bus.regWriteEnable, 1'b1);
    check("add_waddr", {27'd0, bus.regWriteAddr}, 32'd3);
    check("add_wdata", bus.regWriteData, 32'd12);
    checkBit("add_done", bus.done, 1'b1);
    step();
    checkBit("add_ready_again", bus.instrReady, 1'b1);
    check("add_model_reg3", mRegs[3], 32'd12);
    check("add_env_reg3", envRegs[3], 32'd12);

    // SUB with immediate -1: 10 - (-1) = 11.
    setReg(1, 32'd10);
    issue(mkI(1, 6, 1, 15'h7FFF), 0);
    step();
    check("subi_alu_in1", bus.aluInputData1, 32'd10);
    check("subi_alu_in2", bus.aluInputData2, 32'hFFFF_FFFF);
    step();
    checkBit("subi_we", bus.regWriteEnable, 1'b1);
    check("subi_wdata", bus.regWriteData, 32'd11);
    step();

    // Illegal opcode 20, then a legal ADD still retires.
    issue(mkR(20, 4, 1, 2), 0);
    step();
    check("illegal_alu_op", {26'd0, bus.aluOpCode}, 32'd20);
    step();
    checkBit("illegal_flag", bus.illegalOp, 1'b1);
    checkBit("illegal_no_we", bus.regWriteEnable, 1'b0);
    checkBit("illegal_done", bus.done, 1'b1);
    step();
    issue(mkR(0, 7, 1, 2), 0);
    step();
    step();
    checkBit("post_illegal_we", bus.regWriteEnable, 1'b1);
    check("post_illegal_wdata", bus.regWriteData, 32'd17);
    checkBit("post_illegal_sticky", bus.illegalOp, 1'b1);
    step();

    // ADD into r0: result 9, no write, done pulses.
    setReg(1, 32'd5);
    setReg(4, 32'd4);
    issue(mkR(0, 0, 1, 4), 0);
    step();
    step();
    check("rd0_model_result", mRes, 32'd9);
    checkBit("rd0_no_we", bus.regWriteEnable, 1'b0);
    checkBit("rd0_done", bus.done, 1'b1);
    step();

    // DIV 8 by immediate 0.
    setReg(1, 32'd8);
    issue(mkI(3, 8, 1, 15'h0), 0);
    step();
    step();
    checkBit("div0_done", bus.done, 1'b1);
`ifdef ALU_DIVZERO_TRAP_EN
    checkBit("div0_flag", bus.divZeroError, 1'b1);
    checkBit("div0_no_we", bus.regWriteEnable, 1'b0);
`else
    checkBit("div0_flag", bus.divZeroError, 1'b0);
    checkBit("div0_we", bus.regWriteEnable, 1'b1);
    check("div0_waddr", {27'd0, bus.regWriteAddr}, 32'd8);
`endif
    step();

    // Reset during EXEC; a second word held on instrValid throughout.
    prev9 = envRegs[9];
    issue(mkR(0, 9, 1, 2), 1);
    bus.instrWord = mkR(1, 10, 1, 2);
    c0 = mAcceptCount;
    step();
    reset = 1'b1;
    step();
    checkBit("abort_ready_in_reset", bus.instrReady, 1'b0);
    checkBit("abort_no_done", bus.done, 1'b0);
    checkBit("abort_no_we", bus.regWriteEnable, 1'b0);
    reset = 1'b0;
    #1;
    checkBit("abort_ready_after_release", bus.instrReady, 1'b1);
    step();
    check("abort_second_accepted", mAcceptCount, c0 + 1);
    checkBit("abort_second_busy", bus.instrReady, 1'b0);
    check("abort_second_rs1", {27'd0, bus.regReadAddr1}, 32'd1);
    bus.instrValid = 1'b0;
    repeat (3) step();
    check("abort_reg9_untouched", envRegs[9], prev9);
    check("abort_second_result", envRegs[10], 32'd1);
    checkBit("abort_flags_cleared", bus.illegalOp, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int gap, sel, op;
      logic [14:0] low;
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        bus.instrValid = 1'b0;
        repeat (gap) step();
      end
      if (!mPending && $urandom_range(0, 4) == 0) setReg($urandom_range(1, 31), 32'd0);
      sel = $urandom_range(0, 9);
      if (sel == 0)     op = $urandom_range(14, 63);
      else if (sel < 3) op = $urandom_range(3, 4);
      else              op = $urandom_range(0, 13);
      low = ($urandom_range(0, 3) == 0) ? 15'd0 : 15'($urandom);
      issue({op[5:0], 5'($urandom), 5'($urandom), 1'($urandom), low}, 0);
    end
    bus.instrValid = 1'b0;
    repeat (6) step();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
